// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cmp_pkg
//  Shared constants and FSM encoding for the sequential nibble comparator.
//  Revision: 1.0  initial release
// ============================================================================
package cmp_pkg;

    // Width of one comparison slice
    localparam int NIBBLE_W = 4;

    // Comparator controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/eq4.sv
`default_nettype none
// ============================================================================
//  Module  : eq4
//  4-bit equality comparator; the only equality logic in the comparator.
//  Revision: 1.0  initial release
// ============================================================================
module eq4
    import cmp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    output logic                eq_o
);

    assign eq_o = (a_i == b_i);

endmodule : eq4
`default_nettype wire

// File: rtl/seq_cmp16.sv
`default_nettype none
// ============================================================================
//  Module  : seq_cmp16
//  Sequential operand comparator: checks one nibble per cycle, LSB first,
//  stopping at the first mismatch, and reports equality plus the index of
//  the lowest mismatching nibble through a valid/ready handshake.
//  Revision: 1.0  initial release
// ============================================================================
module seq_cmp16
    import cmp_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int IDXW    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*NIBBLES-1:0]      a,
    input  logic [4*NIBBLES-1:0]      b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      eq,
    output logic [IDXW-1:0]           mis_idx
);

    localparam int              c_op_w     = NIBBLE_W * NIBBLES;
    localparam logic [IDXW-1:0] c_idx_last = IDXW'(NIBBLES - 1);
    localparam logic [IDXW-1:0] c_idx_one  = IDXW'(1);

    state_t              state_q, state_d;
    logic [c_op_w-1:0]   a_q, a_d;
    logic [c_op_w-1:0]   b_q, b_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                eq_q, eq_d;
    logic [IDXW-1:0]     mis_q, mis_d;

    logic [NIBBLE_W-1:0] w_nib_a;
    logic [NIBBLE_W-1:0] w_nib_b;
    logic                w_nib_eq;

    // Select the nibble of each stored operand addressed by the running index
    always_comb begin
        w_nib_a = '0;
        w_nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == i[IDXW-1:0]) begin
                w_nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                w_nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    eq4 u_eq4 (
        .a_i  (w_nib_a),
        .b_i  (w_nib_b),
        .eq_o (w_nib_eq)
    );

    // Next-state logic: accept, walk nibbles, hold result, abort on clear
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        mis_d   = mis_q;
        if (clear) begin
            // Result is discarded; eq/mis_idx must read zero outside DONE
            state_d = IDLE;
            eq_d    = 1'b0;
            mis_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!w_nib_eq) begin
                        state_d = DONE;
                        eq_d    = 1'b0;
                        mis_d   = idx_q;
                    end else if (idx_q == c_idx_last) begin
                        state_d = DONE;
                        eq_d    = 1'b1;
                        mis_d   = '0;
                    end else begin
                        idx_d   = idx_q + c_idx_one;
                    end
                end
                DONE: begin
                    // No accept in the consume cycle: IDLE is only reached next edge
                    if (out_ready) begin
                        state_d = IDLE;
                        eq_d    = 1'b0;
                        mis_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    eq_d    = 1'b0;
                    mis_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            mis_q   <= mis_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign eq        = eq_q;
    assign mis_idx   = mis_q;

endmodule : seq_cmp16
`default_nettype wire

// File: tb/tb_seq_cmp16.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seq_cmp16
//  Self-checking bench for seq_cmp16 against a nibble-scan reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_seq_cmp16;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [4*N-1:0]  a;
    logic [4*N-1:0]  b;
    logic            out_valid;
    logic            out_ready;
    logic            eq;
    logic [IDXW-1:0] mis_idx;

    int n_checks = 0;
    int n_errors = 0;

    seq_cmp16 #(
        .NIBBLES (N),
        .IDXW    (IDXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .mis_idx   (mis_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: lowest differing nibble decides result and latency
    function automatic void model(input logic [4*N-1:0] av, input logic [4*N-1:0] bv,
                                  output bit e, output int mis, output int lat);
        logic [4*N-1:0] diff;
        diff = av ^ bv;
        e    = 1'b1;
        mis  = 0;
        lat  = N;
        for (int i = N - 1; i >= 0; i--) begin
            if (((diff >> (4 * i)) & 16'hF) != 0) begin
                e   = 1'b0;
                mis = i;
                lat = i + 1;
            end
        end
    endfunction

    // Full transaction: offer, measure latency, hold, consume
    task automatic run_op(input logic [4*N-1:0] av, input logic [4*N-1:0] bv,
                          input int hold, input bit overlap);
        bit e_exp;
        int mis_exp;
        int lat_exp;
        int lat;
        bit seen;
        model(av, bv, e_exp, mis_exp, lat_exp);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < N + 4) begin
            @(posedge clk); #1;
            lat++;
            a = 16'($urandom);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) lat = -1;
        chk("latency", lat, lat_exp);
        chk("eq", {31'd0, eq}, {31'd0, e_exp});
        chk("mis_idx", {30'd0, mis_idx}, mis_exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            b = 16'($urandom);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_eq", {31'd0, eq}, {31'd0, e_exp});
            chk("hold_mis", {30'd0, mis_idx}, mis_exp);
        end
        out_ready = 1'b1;
        in_valid  = overlap;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("consume_in_ready", {31'd0, in_ready}, 32'd1);
        chk("consume_valid", {31'd0, out_valid}, 32'd0);
        chk("consume_eq", {31'd0, eq}, 32'd0);
        chk("consume_mis", {30'd0, mis_idx}, 32'd0);
    endtask

    // Count cycles where a result shows up although none is allowed
    task automatic expect_no_result(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        logic [4*N-1:0] ra;
        logic [4*N-1:0] rb;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_eq", {31'd0, eq}, 32'd0);
        chk("rst_mis", {30'd0, mis_idx}, 32'd0);
        #9 rst_n = 1'b1;

        // Directed cases, first accept right after reset release
        run_op(16'hBEEF, 16'hBEEF, 0, 1'b0);
        run_op(16'h1234, 16'h1235, 0, 1'b0);
        run_op(16'hA000, 16'hB000, 5, 1'b0);
        // New offer in the consume cycle must not be taken
        run_op(16'h00F0, 16'h0000, 1, 1'b1);

        // Clear in RUN at idx 2, with in_valid and out_ready also high
        in_valid = 1'b1; a = 16'hBEEF; b = 16'hBEEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("clr_run_in_ready", {31'd0, in_ready}, 32'd1);
        chk("clr_run_valid", {31'd0, out_valid}, 32'd0);
        expect_no_result("clr_run_stale", 6);

        // Clear in DONE discards the result
        in_valid = 1'b1; a = 16'h1234; b = 16'h1235;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_clr_done_valid", {31'd0, out_valid}, 32'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_done_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_done_eq", {31'd0, eq}, 32'd0);

        // Clear in IDLE beats an offer
        clear = 1'b1; in_valid = 1'b1; a = 16'h5555; b = 16'h5555;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-RUN
        in_valid = 1'b1; a = 16'hA000; b = 16'hB000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_eq", {31'd0, eq}, 32'd0);
        chk("arst_mis", {30'd0, mis_idx}, 32'd0);
        #2 rst_n = 1'b1;
        expect_no_result("arst_stale", 6);
        run_op(16'hCAFE, 16'hCAFE, 2, 1'b0);

        // Randomized pairs: b derived from a with random nibbles disturbed
        for (int t = 0; t < 40; t++) begin
            ra = 16'($urandom);
            rb = ra;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) rb[i*4 +: 4] = 4'($urandom);
            end
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_seq_cmp16
`default_nettype wire
